// File: rtl/action_agent_pkg.sv
// Shared parameters, FSM encoding and LFSR constants
// for the action agent and its LFSR.
package action_agent_pkg;

  localparam int STATES        = 16;
  localparam int STATES_WIDTH  = $clog2(STATES);
  localparam int ACTIONS       = 4;
  localparam int ACTIONS_WIDTH = $clog2(ACTIONS);
  localparam int DATA_WIDTH    = 16;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] sat_inc(
    input logic [DATA_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/action_agent_if.sv
// Agent <-> Q core bundle; master is the agent side,
// slave is the Q core side.
interface action_agent_if;
  import action_agent_pkg::*;

  logic                     i_en;
  logic [STATES_WIDTH-1:0]  i_st;
  logic                     i_valid_st;
  logic                     i_valid_upd;
  logic                     o_start;
  logic [STATES_WIDTH-1:0]  o_first_st;
  logic [ACTIONS_WIDTH-1:0] o_at;
  logic                     o_valid;
  logic                     o_finish;
  logic                     o_busy;
  logic [DATA_WIDTH-1:0]    o_episode;
  logic [DATA_WIDTH-1:0]    o_steps;

  modport master (
    input  i_en, i_st, i_valid_st, i_valid_upd,
    output o_start, o_first_st, o_at, o_valid,
    output o_finish, o_busy, o_episode, o_steps
  );

  modport slave (
    output i_en, i_st, i_valid_st, i_valid_upd,
    input  o_start, o_first_st, o_at, o_valid,
    input  o_finish, o_busy, o_episode, o_steps
  );

endinterface

// File: rtl/action_agent_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11,
// shifting left with feedback into bit 0.
module lfsr16
  import action_agent_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [15:0] i_seed,
  output logic [15:0] o_q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= i_seed;
    end else if (i_en) begin
      r_q <= {r_q[14:0], ^(r_q & LFSR_TAPS)};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/action_agent.sv
// Episode sequencer that feeds random actions to the
// Q core and counts steps and episodes.
module action_agent
  import action_agent_pkg::*;
#(
  parameter int          EPISODES    = 16,
  parameter int          MAX_STEPS   = 64,
  parameter int          FIRST_STATE = 0,
  parameter int          GOAL_STATE  = STATES - 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic           clk,
  input logic           rst,
  action_agent_if.master io_bus
);

  localparam logic [STATES_WIDTH-1:0] GOAL =
    STATES_WIDTH'(GOAL_STATE);
  localparam logic [STATES_WIDTH-1:0] FIRST =
    STATES_WIDTH'(FIRST_STATE);
  localparam logic [DATA_WIDTH-1:0] STEP_END =
    DATA_WIDTH'(MAX_STEPS - 1);
  localparam logic [DATA_WIDTH:0] EP_END =
    (DATA_WIDTH+1)'(EPISODES);

  if (ACTIONS != (1 << ACTIONS_WIDTH)) begin : g_bad
    $error("ACTIONS must be a power of two");
  end

  state_t                r_state;
  state_t                w_next;
  logic                  r_wait;
  logic                  w_wait;
  logic                  r_finish;
  logic                  w_finish;
  logic [DATA_WIDTH-1:0] r_steps;
  logic [DATA_WIDTH-1:0] w_steps;
  logic [DATA_WIDTH-1:0] r_episode;
  logic [DATA_WIDTH-1:0] w_episode;
  logic                  w_valid;
  logic                  w_goal;
  logic                  w_last;
  logic                  w_ep_last;
  logic [15:0]           w_seed;
  logic [15:0]           w_lfsr;
  logic                  w_unused;

  assign w_seed = (SEED == 16'h0) ? LFSR_DEFAULT : SEED;

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_valid),
    .i_seed (w_seed),
    .o_q    (w_lfsr)
  );

  assign w_goal = io_bus.i_valid_st
               && (io_bus.i_st == GOAL);
  assign w_last = (r_steps == STEP_END);
  assign w_ep_last =
    ({1'b0, r_episode} + 1'b1) == EP_END;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= 1'b0;
      r_finish  <= 1'b0;
      r_steps   <= '0;
      r_episode <= '0;
    end else begin
      r_state   <= w_next;
      r_wait    <= w_wait;
      r_finish  <= w_finish;
      r_steps   <= w_steps;
      r_episode <= w_episode;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_wait    = r_wait;
    w_finish  = 1'b0;
    w_steps   = r_steps;
    w_episode = r_episode;
    w_valid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_bus.i_en) w_next = S_START;
      end
      S_START: begin
        w_valid = 1'b1;
        w_steps = '0;
        w_next  = S_RUN;
      end
      S_RUN: begin
        if (io_bus.i_valid_upd) w_steps = sat_inc(r_steps);
        w_valid = io_bus.i_valid_upd && !w_goal && !w_last;
        // goal without its update: one update still in flight
        if (w_goal) begin
          w_next = S_DRAIN;
          w_wait = !io_bus.i_valid_upd;
        end else if (io_bus.i_valid_upd && w_last) begin
          w_next = S_DRAIN;
          w_wait = 1'b0;
        end
      end
      S_DRAIN: begin
        if (r_wait && io_bus.i_valid_upd) begin
          w_steps = sat_inc(r_steps);
        end
        if (!r_wait || io_bus.i_valid_upd) begin
          w_wait    = 1'b0;
          w_episode = sat_inc(r_episode);
          if (w_ep_last) begin
            w_next   = S_DONE;
            w_finish = 1'b1;
          end else begin
            w_next = S_START;
          end
        end
      end
      S_DONE: begin
        if (!io_bus.i_en) begin
          w_next    = S_IDLE;
          w_episode = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign io_bus.o_start    = (r_state == S_START);
  assign io_bus.o_first_st =
    (r_state == S_START) ? FIRST : '0;
  assign io_bus.o_at       = w_lfsr[ACTIONS_WIDTH-1:0];
  assign io_bus.o_valid    = w_valid;
  assign io_bus.o_finish   = r_finish;
  assign io_bus.o_busy     = (r_state != S_IDLE)
                          && (r_state != S_DONE);
  assign io_bus.o_episode  = r_episode;
  assign io_bus.o_steps    = r_steps;

  assign w_unused = ^w_lfsr[15:ACTIONS_WIDTH];

endmodule

// File: tb/tb_action_agent.sv
// Directed bench: step limit, goal, finish, simultaneous
// events and mid-episode reset, with an action scoreboard.
module tb_action_agent;
  import action_agent_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  action_agent_if ifc ();

  action_agent #(
    .EPISODES    (2),
    .MAX_STEPS   (8),
    .FIRST_STATE (0),
    .GOAL_STATE  (15),
    .SEED        (16'hACE1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (ifc)
  );

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          n_finish = 0;
  logic        exp_v    = 1'b0;
  logic [15:0] m_lfsr;
  logic [1:0]  q_at[$];

  always @(negedge clk) if (ifc.o_finish) n_finish++;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push();
    q_at.push_back(m_lfsr[1:0]);
    m_lfsr = nxt(m_lfsr);
  endtask

  task automatic cyc(input string tag, input logic v);
    exp_v = v;
    @(negedge clk);
    chk({tag, ".valid"}, 32'(ifc.o_valid), 32'(exp_v));
    if (ifc.o_valid) begin
      chk({tag, ".qsz"}, 32'(q_at.size() > 0), 32'd1);
      if (q_at.size() > 0)
        chk({tag, ".at"}, 32'(ifc.o_at), 32'(q_at.pop_front()));
    end else begin
      chk({tag, ".hold"}, 32'(ifc.o_at), 32'(m_lfsr[1:0]));
    end
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    ifc.i_valid_upd = 1'b0;
    ifc.i_valid_st  = 1'b0;
    exp_v = 1'b0;
  endtask

  task automatic upd_gap(input string tag, input int k);
    ifc.i_valid_upd = 1'b1;
    push();
    cyc($sformatf("%s.u%0d", tag, k), 1'b1);
    fin();
    cyc($sformatf("%s.g%0d", tag, k), 1'b0);
    chk($sformatf("%s.steps%0d", tag, k),
        32'(ifc.o_steps), 32'(k));
    fin();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".start"}, 32'(ifc.o_start), 32'd0);
    chk({tag, ".valid"}, 32'(ifc.o_valid), 32'd0);
    chk({tag, ".finish"}, 32'(ifc.o_finish), 32'd0);
    chk({tag, ".busy"}, 32'(ifc.o_busy), 32'd0);
    chk({tag, ".first"}, 32'(ifc.o_first_st), 32'd0);
    chk({tag, ".steps"}, 32'(ifc.o_steps), 32'd0);
    chk({tag, ".ep"}, 32'(ifc.o_episode), 32'd0);
  endtask

  initial begin
    ifc.i_en        = 1'b0;
    ifc.i_st        = '0;
    ifc.i_valid_st  = 1'b0;
    ifc.i_valid_upd = 1'b0;
    m_lfsr = 16'hACE1;

    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    ifc.i_en = 1'b1;
    cyc("idle", 1'b0);
    chk("idle.start", 32'(ifc.o_start), 32'd0);
    fin();
    push();
    cyc("start1", 1'b1);
    chk("start1.start", 32'(ifc.o_start), 32'd1);
    chk("start1.first", 32'(ifc.o_first_st), 32'd0);
    chk("start1.at", 32'(ifc.o_at), 32'd1);
    chk("start1.busy", 32'(ifc.o_busy), 32'd1);
    fin();

    cyc("ep1.run", 1'b0);
    fin();
    for (int k = 1; k < 8; k++) upd_gap("ep1", k);
    ifc.i_valid_upd = 1'b1;
    cyc("ep1.u8", 1'b0);
    fin();
    cyc("ep1.drain", 1'b0);
    chk("ep1.drain.steps", 32'(ifc.o_steps), 32'd8);
    chk("ep1.drain.ep", 32'(ifc.o_episode), 32'd0);
    chk("ep1.drain.busy", 32'(ifc.o_busy), 32'd1);
    chk("ep1.drain.start", 32'(ifc.o_start), 32'd0);
    fin();
    push();
    cyc("start2", 1'b1);
    chk("start2.start", 32'(ifc.o_start), 32'd1);
    chk("start2.ep", 32'(ifc.o_episode), 32'd1);
    fin();

    cyc("ep2.run", 1'b0);
    chk("ep2.run.steps", 32'(ifc.o_steps), 32'd0);
    fin();
    for (int k = 1; k <= 3; k++) upd_gap("ep2", k);
    ifc.i_st = 4'd15;
    ifc.i_valid_st = 1'b1;
    cyc("ep2.goal", 1'b0);
    fin();
    for (int k = 0; k < 2; k++) begin
      cyc("ep2.drain", 1'b0);
      chk("ep2.drain.busy", 32'(ifc.o_busy), 32'd1);
      chk("ep2.drain.steps", 32'(ifc.o_steps), 32'd3);
      chk("ep2.drain.start", 32'(ifc.o_start), 32'd0);
      fin();
    end
    ifc.i_valid_upd = 1'b1;
    cyc("ep2.drainupd", 1'b0);
    fin();
    cyc("done", 1'b0);
    chk("done.finish", 32'(ifc.o_finish), 32'd1);
    chk("done.busy", 32'(ifc.o_busy), 32'd0);
    chk("done.steps", 32'(ifc.o_steps), 32'd4);
    chk("done.ep", 32'(ifc.o_episode), 32'd2);
    fin();
    for (int k = 0; k < 3; k++) begin
      ifc.i_valid_upd = 1'b1;
      ifc.i_valid_st  = 1'b1;
      cyc("hold", 1'b0);
      chk("hold.finish", 32'(ifc.o_finish), 32'd0);
      chk("hold.busy", 32'(ifc.o_busy), 32'd0);
      chk("hold.start", 32'(ifc.o_start), 32'd0);
      chk("hold.ep", 32'(ifc.o_episode), 32'd2);
      chk("hold.steps", 32'(ifc.o_steps), 32'd4);
      fin();
    end
    ifc.i_en = 1'b0;
    cyc("leave", 1'b0);
    fin();
    ifc.i_valid_upd = 1'b1;
    cyc("idle2", 1'b0);
    chk("idle2.ep", 32'(ifc.o_episode), 32'd0);
    chk("idle2.busy", 32'(ifc.o_busy), 32'd0);
    chk("idle2.steps", 32'(ifc.o_steps), 32'd4);
    chk("finish.count", 32'(n_finish), 32'd1);
    fin();

    ifc.i_en = 1'b1;
    cyc("r2.idle", 1'b0);
    fin();
    push();
    cyc("r2.start", 1'b1);
    chk("r2.start.start", 32'(ifc.o_start), 32'd1);
    fin();
    cyc("r2.run", 1'b0);
    chk("r2.run.steps", 32'(ifc.o_steps), 32'd0);
    fin();
    for (int k = 1; k <= 2; k++) upd_gap("r2", k);
    ifc.i_valid_upd = 1'b1;
    ifc.i_valid_st  = 1'b1;
    cyc("simul", 1'b0);
    fin();
    cyc("simul.drain", 1'b0);
    chk("simul.steps", 32'(ifc.o_steps), 32'd3);
    chk("simul.busy", 32'(ifc.o_busy), 32'd1);
    chk("simul.start", 32'(ifc.o_start), 32'd0);
    fin();
    push();
    cyc("r2.start2", 1'b1);
    chk("r2.start2.start", 32'(ifc.o_start), 32'd1);
    chk("r2.start2.ep", 32'(ifc.o_episode), 32'd1);
    fin();
    cyc("r2b.run", 1'b0);
    fin();
    for (int k = 1; k <= 5; k++) upd_gap("r2b", k);

    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    ifc.i_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    m_lfsr = 16'hACE1;
    chk("midrst.qsz", 32'(q_at.size()), 32'd0);
    cyc("r3.idle", 1'b0);
    chk("r3.idle.busy", 32'(ifc.o_busy), 32'd0);
    fin();
    ifc.i_en = 1'b1;
    cyc("r3.en", 1'b0);
    fin();
    push();
    cyc("r3.start", 1'b1);
    chk("r3.start.start", 32'(ifc.o_start), 32'd1);
    chk("r3.start.at", 32'(ifc.o_at), 32'd1);
    fin();
    cyc("r3.run", 1'b0);
    chk("finish.total", 32'(n_finish), 32'd1);
    fin();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
